// File: rtl/alu_flag_stage.sv
// alu_flag_stage: derives NZCV for each ALU result, buffers results in a 2-entry queue, owns the architectural flags
module alu_flag_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic [1:0]       in_ctrl,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_setflags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] retire_count
);
    logic [1:0]       count;
    logic [WIDTH-1:0] tail_result;
    logic [3:0]       tail_flags;
    logic             tail_sf;
    logic             head_sf;
    logic             res_msb;
    logic             c;
    logic             v;
    logic [3:0]       new_flags;
    logic             acc;
    logic             ret;
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign acc       = in_valid && in_ready;
    assign ret       = out_valid && out_ready;
    assign res_msb   = in_result[WIDTH-1];
    assign c         = in_ctrl[1] ? 1'b0 : in_cout;
    assign v         = in_ctrl == 2'b00 ? (in_a_msb == in_b_msb) && (res_msb != in_a_msb) :
                       in_ctrl == 2'b01 ? (in_a_msb != in_b_msb) && (res_msb != in_a_msb) : 1'b0;
    assign new_flags = {res_msb, in_result == '0, c, v};
    // head registers drive the outputs directly; tail is only written when the head is occupied and staying
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= 2'd0;
            out_result   <= '0;
            out_flags    <= 4'b0000;
            head_sf      <= 1'b0;
            tail_result  <= '0;
            tail_flags   <= 4'b0000;
            tail_sf      <= 1'b0;
            nzcv         <= 4'b0000;
            retire_count <= '0;
        end else begin
            count <= count + {1'b0, acc} - {1'b0, ret};
            if (ret && count == 2'd2) begin
                out_result <= tail_result;
                out_flags  <= tail_flags;
                head_sf    <= tail_sf;
            end else if (acc && (count == 2'd0 || ret)) begin
                out_result <= in_result;
                out_flags  <= new_flags;
                head_sf    <= in_setflags;
            end
            if (acc && count == 2'd1 && !ret) begin
                tail_result <= in_result;
                tail_flags  <= new_flags;
                tail_sf     <= in_setflags;
            end
            if (ret && head_sf)
                nzcv <= out_flags;
            if (ret)
                retire_count <= retire_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: random and directed stimulus checked against a queue-based arithmetic model
module tb_alu_flag_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_cout;
    logic [1:0] in_ctrl;
    logic       in_a_msb;
    logic       in_b_msb;
    logic       in_setflags;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] nzcv;
    logic [7:0] retire_count;

    alu_flag_stage #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_cout(in_cout),
        .in_ctrl(in_ctrl), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_setflags(in_setflags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .nzcv(nzcv), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        logic [3:0] fl;
        logic       sf;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_nzcv = 4'b0000;
    logic [7:0] m_cnt = 8'd0;
    int         checks = 0;
    int         errors = 0;
    int         a_v, b_v, op_v;
    bit         sf_v;

    // expected entry from the operands using plain integer arithmetic
    function automatic ent_t model(int a, int b, int op, bit sf);
        ent_t e;
        int sa = a > 7 ? a - 16 : a;
        int sb = b > 7 ? b - 16 : b;
        int r;
        int s;
        bit c, v;
        c = 0;
        v = 0;
        case (op)
            0: begin r = a + b; s = sa + sb; c = r > 15; v = s > 7 || s < -8; end
            1: begin r = a - b; s = sa - sb; c = a >= b; v = s > 7 || s < -8; end
            2: r = a ^ b;
            default: r = 15 - a;
        endcase
        r = r & 15;
        e.res = 4'(r);
        e.fl = {r > 7, r == 0, c, v};
        e.sf = sf;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_nzcv <= 4'b0000;
            m_cnt <= 8'd0;
        end else if (out_ready && q.size() > 0) begin
            if (q[0].sf)
                m_nzcv <= q[0].fl;
            m_cnt <= m_cnt + 8'd1;
            if (in_valid && q.size() < 2)
                q.push_back(model(a_v, b_v, op_v, sf_v));
            q.pop_front();
        end else if (in_valid && q.size() < 2)
            q.push_back(model(a_v, b_v, op_v, sf_v));
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_result", out_result, q[0].res);
                chk("out_flags", out_flags, q[0].fl);
            end
            chk("nzcv", nzcv, m_nzcv);
            chk("retire_count", retire_count, m_cnt);
        end
    end

    // drives the ALU-side signals as the flagless ALU would produce them
    task automatic set_op(int a, int b, int op, bit sf);
        logic [4:0] s;
        a_v = a;
        b_v = b;
        op_v = op;
        sf_v = sf;
        case (op)
            0: s = 5'(a + b);
            1: s = 5'(a + (15 - b) + 1);
            2: s = {1'($urandom), 4'(a ^ b)};
            default: s = {1'($urandom), 4'(15 - a)};
        endcase
        in_result = s[3:0];
        in_cout = s[4];
        in_ctrl = 2'(op);
        in_a_msb = a > 7;
        in_b_msb = b > 7;
        in_setflags = sf;
    endtask

    task automatic send(int a, int b, int op, bit sf);
        bit r;
        int n = 0;
        set_op(a, b, op, sf);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        if (!r)
            chk("send_timeout", 8'(r), 8'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        in_valid = 0;
        out_ready = 0;
        set_op(0, 0, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1, 2, 0, 1);
        send(3, 4, 1, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_nzcv", nzcv, 0);
        chk("rst_retire_count", retire_count, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("empty_after_reset", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 1;
        send(3, 14, 0, 1);
        chk("add3_14_result", out_result, 8'h1);
        chk("add3_14_flags", out_flags, 8'b0010);
        @(posedge clk);
        #1;
        chk("add3_14_nzcv", nzcv, 8'b0010);
        chk("add3_14_count", retire_count, 1);
        send(7, 4, 0, 1);
        chk("add7_4_flags", out_flags, 8'b1001);
        @(posedge clk);
        #1;
        chk("add7_4_nzcv", nzcv, 8'b1001);
        send(2, 6, 1, 1);
        chk("sub2_6_flags", out_flags, 8'b1000);
        @(posedge clk);
        #1;
        chk("sub2_6_nzcv", nzcv, 8'b1000);
        send(3, 3, 2, 0);
        chk("xor_flags", out_flags, 8'b0100);
        @(posedge clk);
        #1;
        chk("xor_nosf_nzcv", nzcv, 8'b1000);
        send(3, 3, 2, 1);
        @(posedge clk);
        #1;
        chk("xor_sf_nzcv", nzcv, 8'b0100);
        chk("count_after_directed", retire_count, 5);
        out_ready = 0;
        fork
            begin
                send(5, 1, 0, 1);
                send(9, 9, 0, 1);
                send(4, 12, 1, 1);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_head", out_result, 8'h6);
                @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_retired", retire_count, 8);
        chk("bp_drained", out_valid, 0);
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        out_ready = 1;
        set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
        in_valid = 1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
            if (i == 256)
                chk("stream_255", retire_count, 8'd255);
            if (i == 257)
                chk("stream_wrap", retire_count, 8'd0);
        end
        in_valid = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = 1'($urandom);
                set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
            end
            out_ready = 1'($urandom);
        end
        in_valid = 0;
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_drained", out_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
